// File: rtl/pudding_ctrl_pkg.sv
// Shared types and constants for the PUDDING chain sequencer.
//   op_e    : host command opcodes
//   state_e : sequencer FSM states
//   op_dir  : transfer direction used by an op's transfer phase
package pudding_ctrl_pkg;

   localparam int   CHAIN_W_DEFAULT = 128;
   localparam logic DIR_TO_STATE    = 1'b1;
   localparam logic DIR_TO_CHAIN    = 1'b0;

   typedef enum logic [1:0] {
      OP_APPLY    = 2'b00,
      OP_LOAD     = 2'b01,
      OP_COMMIT   = 2'b10,
      OP_READBACK = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_XS   = 3'd1,
      ST_XP   = 3'd2,
      ST_XH   = 3'd3,
      ST_BS   = 3'd4,
      ST_BP   = 3'd5,
      ST_RESP = 3'd6
   } state_e;

   // READBACK pulls the state register into the chain; every other op pushes chain to state.
   function automatic logic op_dir(input op_e op);
      logic dir;
      if (op == OP_READBACK) begin
         dir = DIR_TO_CHAIN;
      end else begin
         dir = DIR_TO_STATE;
      end
      return dir;
   endfunction

endpackage

// File: rtl/pudding_phase_timer.sv
// GAP-cycle phase timer.
//   clk_i   : system clock
//   rst_i   : synchronous reset, active-high
//   start_i : load the timer; the phase it times begins on the following cycle
//   done_o  : high on the last cycle of a GAP-cycle phase
module pudding_phase_timer #(
   parameter int GAP = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   output logic done_o
);

   localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Reload on start, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = CW'(GAP - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pudding_chain_ctrl.sv
// Sequencer driving the PUDDING daisychain/state register serial pins.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/ready/op/data : command channel (APPLY, LOAD, COMMIT, READBACK)
//   rsp_valid/ready/data  : response channel, bits shifted out of chain MSB
//   busy                  : sequencer is running an op
//   chain_datum/shift/transfer/dir/stateen : pins toward the chain
//   chain_sout            : chain MSB fed back
// All pin outputs are registered decodes of the FSM state, so they trail the
// state register by one cycle; chain_sout is sampled while the pins show the
// last setup cycle of a bit, i.e. while the FSM itself sits in BP.
module pudding_chain_ctrl
   import pudding_ctrl_pkg::*;
#(
   parameter int CHAIN_W = CHAIN_W_DEFAULT,
   parameter int GAP     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [CHAIN_W-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [CHAIN_W-1:0] rsp_data,
   output logic               busy,
   output logic               chain_datum,
   output logic               chain_shift,
   output logic               chain_transfer,
   output logic               chain_dir,
   output logic               chain_stateen,
   input  logic               chain_sout
);

   localparam int BW = (CHAIN_W > 1) ? $clog2(CHAIN_W) : 1;

   state_e             state_q, state_d;
   op_e                op_q;
   logic [CHAIN_W-1:0] data_q;
   logic [CHAIN_W-1:0] rsp_data_q;
   logic [BW-1:0]      bit_q;
   logic               rsp_valid_q, busy_q;
   logic               datum_q, shift_q, transfer_q, dir_q, stateen_q;

   logic accept_s, last_bit_s, timer_start_s, timer_done_s;

   assign cmd_ready     = (state_q == ST_IDLE) && !rsp_valid_q;
   assign accept_s      = cmd_valid && cmd_ready;
   assign last_bit_s    = (bit_q == BW'(CHAIN_W - 1));
   // The timer is loaded on the edge that enters a timed phase.
   assign timer_start_s = (state_d != state_q) &&
                          ((state_d == ST_XS) || (state_d == ST_XH) || (state_d == ST_BS));

   pudding_phase_timer #(.GAP(GAP)) u_timer (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (timer_start_s),
      .done_o  (timer_done_s)
   );

   // Next-state logic for the phase sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if ((op_e'(cmd_op) == OP_LOAD) || (op_e'(cmd_op) == OP_COMMIT)) begin
                  state_d = ST_BS;
               end else begin
                  state_d = ST_XS;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XS: begin
            if (timer_done_s) begin
               state_d = ST_XP;
            end else begin
               state_d = ST_XS;
            end
         end
         ST_XP: state_d = ST_XH;
         ST_XH: begin
            if (!timer_done_s) begin
               state_d = ST_XH;
            end else if (op_q == OP_READBACK) begin
               state_d = ST_BS;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_BS: begin
            if (timer_done_s) begin
               state_d = ST_BP;
            end else begin
               state_d = ST_BS;
            end
         end
         ST_BP: begin
            if (!last_bit_s) begin
               state_d = ST_BS;
            end else if (op_q == OP_COMMIT) begin
               state_d = ST_XS;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_APPLY;
         data_q      <= '0;
         rsp_data_q  <= '0;
         bit_q       <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         datum_q     <= 1'b0;
         shift_q     <= 1'b0;
         transfer_q  <= 1'b0;
         dir_q       <= 1'b0;
         stateen_q   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (accept_s) begin
            op_q       <= op_e'(cmd_op);
            data_q     <= cmd_data;
            rsp_data_q <= '0;
            bit_q      <= '0;
            stateen_q  <= 1'b1;
         end else if (state_q == ST_BP) begin
            // Pins currently show the last setup cycle: capture sout, advance the bit.
            data_q     <= {data_q[CHAIN_W-2:0], 1'b0};
            rsp_data_q <= {rsp_data_q[CHAIN_W-2:0], chain_sout};
            bit_q      <= last_bit_s ? '0 : bit_q + BW'(1);
         end else begin
            data_q     <= data_q;
            rsp_data_q <= rsp_data_q;
            bit_q      <= bit_q;
         end

         if (state_q == ST_RESP) begin
            rsp_valid_q <= !(rsp_valid_q && rsp_ready);
         end else begin
            rsp_valid_q <= 1'b0;
         end
         busy_q <= (state_q != ST_IDLE) && (state_q != ST_RESP);

         shift_q    <= 1'b0;
         transfer_q <= 1'b0;
         dir_q      <= 1'b0;
         datum_q    <= 1'b0;
         case (state_q)
            ST_XS: dir_q <= op_dir(op_q);
            ST_XP: begin
               dir_q      <= op_dir(op_q);
               transfer_q <= 1'b1;
            end
            ST_XH: dir_q <= op_dir(op_q);
            // READBACK recirculates: datum takes the sout captured for this bit.
            ST_BS: datum_q <= (op_q == OP_READBACK) ? datum_q : data_q[CHAIN_W-1];
            ST_BP: begin
               datum_q <= (op_q == OP_READBACK) ? chain_sout : data_q[CHAIN_W-1];
               shift_q <= 1'b1;
            end
            default: begin
               datum_q <= 1'b0;
               dir_q   <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign busy           = busy_q;
   assign chain_datum    = datum_q;
   assign chain_shift    = shift_q;
   assign chain_transfer = transfer_q;
   assign chain_dir      = dir_q;
   assign chain_stateen  = stateen_q;

endmodule

// File: tb/tb_pudding_chain_ctrl.sv
// Directed bench for pudding_chain_ctrl: instance a (GAP=1) and instance b
// (GAP=3), each wired to a behavioural chain/state register pair.
module tb_pudding_chain_ctrl;
   import pudding_ctrl_pkg::*;

   localparam int W = 128;
   localparam logic [W-1:0] PAT = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   localparam logic [W-1:0] A5  = {16{8'hA5}};
   localparam logic [W-1:0] FF  = {W{1'b1}};
   localparam logic [W-1:0] QAT = ~PAT;
   localparam logic [W-1:0] C0  = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_busy;
   logic a_datum, a_shift, a_transfer, a_dir, a_stateen, a_sout;
   logic [1:0] a_cmd_op;
   logic [W-1:0] a_cmd_data, a_rsp_data;
   logic b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_busy;
   logic b_datum, b_shift, b_transfer, b_dir, b_stateen, b_sout;
   logic [1:0] b_cmd_op;
   logic [W-1:0] b_cmd_data, b_rsp_data;

   pudding_chain_ctrl #(.CHAIN_W(W), .GAP(1)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_op(a_cmd_op), .cmd_data(a_cmd_data), .rsp_valid(a_rsp_valid),
      .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .busy(a_busy),
      .chain_datum(a_datum), .chain_shift(a_shift), .chain_transfer(a_transfer),
      .chain_dir(a_dir), .chain_stateen(a_stateen), .chain_sout(a_sout));

   pudding_chain_ctrl #(.CHAIN_W(W), .GAP(3)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_op(b_cmd_op), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid),
      .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .busy(b_busy),
      .chain_datum(b_datum), .chain_shift(b_shift), .chain_transfer(b_transfer),
      .chain_dir(b_dir), .chain_stateen(b_stateen), .chain_sout(b_sout));

   // Behavioural chain + state registers (sample the pins at every edge).
   logic [W-1:0] a_chain = '0, a_state = '0;
   logic [W-1:0] b_chain = C0, b_state = '0;
   always @(posedge clk) begin
      if (a_shift) a_chain <= {a_chain[W-2:0], a_datum};
      if (a_transfer) begin
         if (a_dir) a_state <= a_chain;
         else       a_chain <= a_state;
      end
      if (b_shift) b_chain <= {b_chain[W-2:0], b_datum};
      if (b_transfer) begin
         if (b_dir) b_state <= b_chain;
         else       b_chain <= b_state;
      end
   end
   assign a_sout = a_chain[W-1];
   assign b_sout = b_chain[W-1];

   // Pulse monitors: counts, over-wide pulses, shift spacing on b.
   int a_sh_total = 0, a_tr_total = 0, a_sh_at_tr = 0, a_wide = 0;
   logic a_prev_sh = 1'b0, a_prev_tr = 1'b0, a_tr_dir = 1'b0;
   int b_sh_total = 0, b_last_sh = 0, b_sp_min = 100000, b_sp_max = 0, b_wide = 0;
   logic b_prev_sh = 1'b0, b_prev_tr = 1'b0, b_tr_dir = 1'b0;
   always @(negedge clk) begin
      a_prev_sh <= a_shift;
      a_prev_tr <= a_transfer;
      b_prev_sh <= b_shift;
      b_prev_tr <= b_transfer;
      if (a_shift) begin
         a_sh_total <= a_sh_total + 1;
         if (a_prev_sh) a_wide <= a_wide + 1;
      end
      if (a_transfer) begin
         a_tr_total <= a_tr_total + 1;
         a_tr_dir   <= a_dir;
         a_sh_at_tr <= a_sh_total;
         if (a_prev_tr) a_wide <= a_wide + 1;
      end
      if (b_shift) begin
         b_sh_total <= b_sh_total + 1;
         b_last_sh  <= cyc;
         if (b_prev_sh) b_wide <= b_wide + 1;
         if (b_sh_total != 0) begin
            if ((cyc - b_last_sh) < b_sp_min) b_sp_min <= cyc - b_last_sh;
            if ((cyc - b_last_sh) > b_sp_max) b_sp_max <= cyc - b_last_sh;
         end
      end
      if (b_transfer) begin
         b_tr_dir <= b_dir;
         if (b_prev_tr) b_wide <= b_wide + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   int a_acc, b_acc;

   // Offer one command; op/data are scrambled right after acceptance.
   task automatic a_start(input logic [1:0] op, input logic [W-1:0] data);
      @(negedge clk);
      check_eq("a_ready_before", W'(a_cmd_ready), W'(1));
      a_cmd_op = op; a_cmd_data = data; a_cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_cmd_valid = 1'b0; a_cmd_op = ~op; a_cmd_data = ~data;
      a_acc = cyc;
   endtask

   task automatic a_finish(output int lat, output logic [W-1:0] rd);
      int n = 0;
      while (!a_rsp_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_eq("a_rsp_timeout", W'(n < 3000), W'(1));
      lat = cyc - a_acc;
      rd  = a_rsp_data;
      a_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_rsp_ready = 1'b0;
      check_eq("a_ready_after", W'(a_cmd_ready), W'(1));
   endtask

   task automatic b_start(input logic [1:0] op, input logic [W-1:0] data);
      @(negedge clk);
      b_cmd_op = op; b_cmd_data = data; b_cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_cmd_valid = 1'b0; b_cmd_op = ~op; b_cmd_data = ~data;
      b_acc = cyc;
   endtask

   task automatic b_wait(output int lat);
      int n = 0;
      while (!b_rsp_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_eq("b_rsp_timeout", W'(n < 3000), W'(1));
      lat = cyc - b_acc;
   endtask

   task automatic b_handshake();
      b_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_rsp_ready = 1'b0;
   endtask

   initial begin
      int lat, s0, t0, n;
      logic [W-1:0] rd, pre;
      rst = 1'b1;
      a_cmd_valid = 1'b0; a_cmd_op = 2'b00; a_cmd_data = '0; a_rsp_ready = 1'b0;
      b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_data = '0; b_rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Reset / idle state.
      check_eq("rst_pins", W'({a_datum, a_shift, a_transfer, a_dir, a_stateen}), W'(0));
      check_eq("rst_rsp_valid", W'(a_rsp_valid), W'(0));
      check_eq("rst_busy", W'(a_busy), W'(0));
      check_eq("rst_rsp_data", a_rsp_data, '0);
      check_eq("rst_cmd_ready", W'(a_cmd_ready), W'(1));

      // COMMIT into a cleared chain.
      s0 = a_sh_total; t0 = a_tr_total;
      a_start(2'b10, PAT);
      a_finish(lat, rd);
      check_eq("commit_lat", W'(lat), W'(260));
      check_eq("commit_rsp", rd, '0);
      check_eq("commit_shifts", W'(a_sh_total - s0), W'(128));
      check_eq("commit_xfers", W'(a_tr_total - t0), W'(1));
      check_eq("commit_xfer_dir", W'(a_tr_dir), W'(1));
      check_eq("commit_xfer_after_shifts", W'(a_sh_at_tr - s0), W'(128));
      check_eq("commit_state", a_state, PAT);
      check_eq("commit_chain", a_chain, PAT);
      check_eq("commit_stateen", W'(a_stateen), W'(1));

      // LOAD returns previous chain, never transfers.
      s0 = a_sh_total; t0 = a_tr_total;
      a_start(2'b01, A5);
      a_finish(lat, rd);
      check_eq("load_lat", W'(lat), W'(257));
      check_eq("load_rsp", rd, PAT);
      check_eq("load_chain", a_chain, A5);
      check_eq("load_state", a_state, PAT);
      check_eq("load_xfers", W'(a_tr_total - t0), W'(0));
      check_eq("load_shifts", W'(a_sh_total - s0), W'(128));

      a_start(2'b01, FF);
      a_finish(lat, rd);
      check_eq("load2_rsp", rd, A5);
      check_eq("load2_chain", a_chain, FF);

      // READBACK: transfer to chain first, then recirculate.
      s0 = a_sh_total; t0 = a_tr_total;
      a_start(2'b11, A5);
      a_finish(lat, rd);
      check_eq("rdbk_lat", W'(lat), W'(260));
      check_eq("rdbk_rsp", rd, PAT);
      check_eq("rdbk_chain", a_chain, PAT);
      check_eq("rdbk_state", a_state, PAT);
      check_eq("rdbk_xfers", W'(a_tr_total - t0), W'(1));
      check_eq("rdbk_xfer_dir", W'(a_tr_dir), W'(0));
      check_eq("rdbk_xfer_first", W'(a_sh_at_tr - s0), W'(0));

      // Reset in the middle of a COMMIT.
      s0 = a_sh_total;
      a_start(2'b10, QAT);
      n = 0;
      while ((a_sh_total - s0) < 40 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("midrst_reached", W'(n < 2000), W'(1));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_pins", W'({a_datum, a_shift, a_transfer, a_dir, a_stateen}), W'(0));
      check_eq("midrst_busy", W'(a_busy), W'(0));
      check_eq("midrst_rsp_valid", W'(a_rsp_valid), W'(0));
      check_eq("midrst_cmd_ready", W'(a_cmd_ready), W'(1));
      rst = 1'b0;
      pre = a_chain;
      a_start(2'b10, QAT);
      a_finish(lat, rd);
      check_eq("recommit_lat", W'(lat), W'(260));
      check_eq("recommit_rsp", rd, pre);
      check_eq("recommit_state", a_state, QAT);
      check_eq("recommit_chain", a_chain, QAT);

      // GAP=3 instance: APPLY then COMMIT with a held-off response.
      b_start(2'b00, FF);
      b_wait(lat);
      check_eq("b_apply_lat", W'(lat), W'(8));
      check_eq("b_apply_rsp", b_rsp_data, '0);
      b_handshake();
      check_eq("b_apply_state", b_state, C0);
      check_eq("b_apply_dir", W'(b_tr_dir), W'(1));

      b_start(2'b10, PAT);
      b_wait(lat);
      check_eq("b_commit_lat", W'(lat), W'(520));
      for (int i = 0; i < 5; i++) begin
         check_eq("b_hold_rsp", b_rsp_data, C0);
         check_eq("b_hold_ready", W'({b_cmd_ready, b_rsp_valid}), W'(1));
         @(negedge clk);
      end
      b_handshake();
      check_eq("b_after_ready", W'(b_cmd_ready), W'(1));
      check_eq("b_commit_state", b_state, PAT);
      check_eq("b_commit_chain", b_chain, PAT);
      check_eq("b_shift_period_min", W'(b_sp_min), W'(4));
      check_eq("b_shift_period_max", W'(b_sp_max), W'(4));
      check_eq("b_wide_pulses", W'(b_wide), W'(0));
      check_eq("a_wide_pulses", W'(a_wide), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pudding_chain_ctrl.md
Name: pudding_chain_ctrl

Overview:
Sequencer that drives the serial control pins of the 128-bit PUDDING daisychain/state register pair: datum, shift, transfer, dir and stateen.
- Accepts whole-word commands over a valid/ready interface.
- Produces the exact shift/transfer pulse trains to load, commit or read back the chain.
- Returns the bits shifted out of the chain MSB.
- Sits between the host-side register interface and the ui_in[4:0] control pins.

Parameters:
CHAIN_W, 128, chain length in bits (≥2).
GAP, 1, clk cycles of setup before each one-cycle pulse (≥1); paces slow external pin paths.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
cmd_op  in  2  00 APPLY, 01 LOAD, 10 COMMIT, 11 READBACK
cmd_data  in  CHAIN_W  payload for LOAD/COMMIT
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_data  out  CHAIN_W  bits captured from chain_sout, first captured bit ends in MSB
busy  out  1  FSM not IDLE/RESP
chain_datum  out  1  to datum pin
chain_shift  out  1  to shift pin
chain_transfer  out  1  to transfer pin
chain_dir  out  1  to dir pin
chain_stateen  out  1  to stateen pin
chain_sout  in  1  chain MSB (daisychain[CHAIN_W-1])

Behaviour:
- Reset (rst=1 at posedge): all chain_* = 0, rsp_valid = 0, rsp_data = 0, busy = 0, FSM = IDLE, counters = 0. Reset overrides everything, including mid-operation; any pending response is dropped. Chain content is undefined afterwards and the host must reissue.
- cmd_ready = (FSM==IDLE) & !rsp_valid. Commands are never accepted while a response is pending.
- chain_stateen: 0 after reset; set to 1 at the first accepted command; stays 1 until reset.
- FSM states:
  - IDLE
  - XS: transfer setup, GAP cycles
  - XP: transfer pulse, 1 cycle
  - XH: transfer hold, GAP cycles
  - BS: bit setup, GAP cycles
  - BP: bit pulse, 1 cycle
  - RESP
- Phase outputs:
  - Pulses are exactly one clk wide, because the chain samples every edge.
  - XS/XP/XH: chain_dir is held at the op's direction. chain_transfer=1 only in XP. chain_shift=0.
  - BS/BP: chain_datum holds the current bit. chain_shift=1 only in BP. chain_transfer=0.
  - chain_sout is sampled on the last BS cycle: rsp_data <= {rsp_data[W-2:0], chain_sout}.
  - Bit counter runs 0..CHAIN_W-1; after the BP with count W-1, go to the next step.
- Op sequences (the first phase starts the cycle after acceptance; rsp_data cleared at acceptance):
  - APPLY: XS→XP→XH with dir=1 (state<=chain), then RESP. rsp_data=0.
  - LOAD: W bits, MSB first (cmd_data[W-1] first), then RESP. Chain ends equal to cmd_data. rsp_data = previous chain. No transfer pulse.
  - COMMIT: as LOAD, then XS/XP/XH with dir=1, then RESP. Final state = chain = cmd_data.
  - READBACK: XS/XP/XH with dir=0 (chain<=state), then W bits with chain_datum = the sout value sampled in the same BS (recirculation), then RESP. rsp_data = state; chain left equal to state; state unchanged.
- Latency from the accept edge to rsp_valid high:
  - LOAD: 1 + W·(GAP+1).
  - COMMIT/READBACK: 1 + W·(GAP+1) + 2·GAP + 1.
  - APPLY: 2·GAP + 2.
  - W=128, GAP=1: COMMIT = 260 cycles.
- RESP: rsp_valid=1, rsp_data stable until the rsp_ready handshake; then IDLE next cycle. busy=0 in RESP.
- cmd_op/cmd_data are registered at acceptance; later changes on those inputs are ignored.
- chain_datum = 0 outside BS/BP. chain_dir = 0 in IDLE/RESP.

Decomposition:
- Package pudding_ctrl_pkg:
  - op_e enum (APPLY, LOAD, COMMIT, READBACK)
  - state_e enum
  - CHAIN_W_DEFAULT = 128
  - DIR_TO_STATE = 1, DIR_TO_CHAIN = 0
- Sub-module pudding_phase_timer: GAP-cycle down-counter with start/done. Used for the XS, XH and BS phases.

Test Plan:
- Reset then idle 5 cycles → every chain_* = 0, rsp_valid = 0, cmd_ready = 1, stateen = 0.
- COMMIT 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 against the chain model (reset chain) → exactly 128 one-cycle shift pulses then one transfer with dir=1; model state = chain = pattern; rsp_data = 0; rsp_valid at cycle 260.
- Model state = pattern, chain overwritten by LOAD of 128'hFFFF…; READBACK → rsp_data = pattern; chain = pattern afterwards; state unchanged; transfer pulses once with dir=0 before any shift.
- LOAD 128'hA5A5… after the COMMIT above → rsp_data = pattern; chain = A5A5…; state unchanged; chain_transfer never high.
- GAP=3, APPLY, then COMMIT with rsp_ready held low 5 cycles:
  - APPLY rsp_valid at cycle 8.
  - COMMIT: shift high 1 cycle, low 3 between pulses.
  - rsp_data stable and cmd_ready low until the handshake.
- rst asserted during COMMIT bit 40 → next cycle all chain_* = 0, busy = 0, rsp_valid = 0, cmd_ready = 1; a fresh COMMIT then completes normally.
